// File: rtl/event_filter_pkg.sv
// Shared mode encodings and the polarity-match helper for the event filter.
package event_filter_pkg;
  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_OFF  = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  function automatic logic pol_ok(input logic [1:0] mode, input logic p);
    case (mode)
      MODE_ALL: return 1'b1;
      MODE_ON:  return p;
      MODE_OFF: return !p;
      default:  return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with a registered head word; head holds its last value once drained.
module event_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_head;

  logic          w_push, w_pop, w_head_upd;
  logic [AW-1:0] w_rd_nxt;
  logic [W-1:0]  w_head_nxt;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_head;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Head follows the next read slot; a write landing in that slot forwards din.
  assign w_rd_nxt   = w_pop ? r_rd + AW'(1) : r_rd;
  assign w_head_nxt = (w_push && r_wr == w_rd_nxt) ? din : r_mem[w_rd_nxt];
  assign w_head_upd = (w_push && empty) || (w_pop && (r_cnt > (AW+1)'(1) || w_push));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd <= w_rd_nxt;
      if (w_head_upd) r_head <= w_head_nxt;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/event_filter_stream.sv
// Streaming polarity/refractory event filter with drop counter and output FIFO.
module event_filter_stream
  import event_filter_pkg::*;
#(
  parameter int XW    = 16,
  parameter int YW    = 16,
  parameter int TW    = 16,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      cfg_mode,
  input  logic [TW-1:0]   cfg_refrac,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XW-1:0]   in_x,
  input  logic [YW-1:0]   in_y,
  input  logic [TW-1:0]   in_t,
  input  logic            in_p,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XW-1:0]   out_x,
  output logic [YW-1:0]   out_y,
  output logic [TW-1:0]   out_t,
  output logic            out_p,
  output logic [CNTW-1:0] drop_count
);
  localparam int EW = XW + YW + TW + 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [TW-1:0] t;
    logic          p;
  } evt_t;

  logic [TW-1:0]   r_last_t;
  logic            r_have_last;
  logic [CNTW-1:0] r_drop;

  evt_t          w_in_ev, w_out_ev;
  logic          w_full, w_empty, w_accept, w_pass, w_ref_ok;
  logic [TW-1:0] w_dt;

  assign w_in_ev  = '{x: in_x, y: in_y, t: in_t, p: in_p};
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;

  // Modular difference keeps the refractory check correct across timestamp wrap.
  assign w_dt     = in_t - r_last_t;
  assign w_ref_ok = !r_have_last || (w_dt >= cfg_refrac);
  assign w_pass   = pol_ok(cfg_mode, in_p) && w_ref_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_t    <= '0;
      r_have_last <= 1'b0;
      r_drop      <= '0;
    end else if (w_accept) begin
      if (w_pass) begin
        r_last_t    <= in_t;
        r_have_last <= 1'b1;
      end else if (r_drop != '1) begin
        r_drop <= r_drop + CNTW'(1);
      end
    end
  end

  event_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept && w_pass),
    .din   (w_in_ev),
    .pop   (out_ready),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_out_ev)
  );

  assign out_valid  = !w_empty;
  assign out_x      = w_out_ev.x;
  assign out_y      = w_out_ev.y;
  assign out_t      = w_out_ev.t;
  assign out_p      = w_out_ev.p;
  assign drop_count = r_drop;
endmodule
